insn_encoder: RTL
=================

INSN_ENCODER -- requirements
Module: insn_encoder

Interface
REQ-001 The module SHALL have one clock, clk, and a synchronous active-low reset, rst_n, sampled on rising clk.
REQ-002 The parameter DEPTH SHALL default to 4 and set the number of output FIFO entries.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  synchronous active-low reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  encoder can accept a request.
REQ-007 in_op  input  3  0 LW, 1 SW, 2 AND, 3 OR, 4 ADD, 5 SUB, 6 BEQ, 7 BLT.
REQ-008 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-009 in_imm  input  13  signed immediate (byte offset for branches).
REQ-010 out_valid  output  1  out_insn holds a valid RV32I word.
REQ-011 out_ready  input  1  consumer takes the word.
REQ-012 out_insn  output  32  encoded instruction.
REQ-013 err_valid  output  1  one-cycle pulse for a rejected request.
REQ-014 err_code  output  2  01 immediate out of range, 10 branch offset misaligned, 00 otherwise.
REQ-015 count  output  3  current FIFO occupancy, 0..DEPTH.

Function
REQ-016 A request SHALL transfer on the rising edge where in_valid and in_ready are both 1.
REQ-017 in_ready SHALL be 1 exactly when count < DEPTH, and SHALL NOT depend combinationally on out_ready or in_valid.
REQ-018 LW SHALL encode as I-type: imm[11:0], rs1, funct3 010, rd, opcode 0000011.
REQ-019 SW SHALL encode as S-type: imm[11:5], rs2, rs1, funct3 010, imm[4:0], opcode 0100011.
REQ-020 AND/OR/ADD/SUB SHALL encode as R-type, opcode 0110011, with funct3/funct7 of 111/0000000, 110/0000000, 000/0000000 and 000/0100000 respectively; in_imm is ignored.
REQ-021 BEQ/BLT SHALL encode as B-type, opcode 1100011, funct3 000/100: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
REQ-022 For LW and SW, in_imm[12] SHALL equal in_imm[11], giving a range of -2048..2047; any other value is a range error (code 01).
REQ-023 For BEQ and BLT, in_imm[0] SHALL be 0; a value of 1 is a misalignment error (code 10).
REQ-024 A rejected request SHALL be consumed but not enqueued, and SHALL produce err_valid=1 with its err_code for exactly the following cycle; otherwise err_valid=0 and err_code=00.
REQ-025 A legal request accepted at edge N SHALL appear on out_insn with out_valid=1 after edge N when the FIFO was empty, giving 1-cycle latency.
REQ-026 Words SHALL leave in acceptance order; a word is popped on an edge where out_valid and out_ready are both 1.
REQ-027 While out_valid=1 and out_ready=0, out_insn SHALL hold stable.
REQ-028 A simultaneous push and pop SHALL leave count unchanged and SHALL be legal at any occupancy below DEPTH, including when count=1.
REQ-029 At count=DEPTH, a pop SHALL raise in_ready on the next cycle; no push occurs in the full cycle.
REQ-030 The FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-031 out_valid SHALL equal (count != 0).

Reset
REQ-032 With rst_n=0 at a rising edge, count SHALL be 0, out_valid 0, err_valid 0, err_code 00, out_insn 0, and pointers 0; in_ready SHALL be 1 from the first cycle after reset.
REQ-033 A reset asserted mid-operation SHALL discard all queued words and any pending error pulse.

Verification
REQ-034 ADD rd=1 rs1=2 rs2=3, out_ready=1 -> out_insn=0x003100B3 one cycle later, count returns to 0.
REQ-035 SUB rd=5 rs1=6 rs2=7 -> 0x407302B3; LW rd=1 rs1=2 imm=-4 -> 0xFFC12083; BEQ rs1=1 rs2=2 imm=8 -> 0x00208463.
REQ-036 out_ready=0, push 4 legal ops -> count=4, in_ready=0; a fifth request is held; then out_ready=1 -> 4 words drain in order and the fifth is accepted the cycle after the first pop.
REQ-037 LW imm=2048 -> err_valid=1, err_code=01 for one cycle, count unchanged; BLT imm=3 -> err_code=10.
REQ-038 Continuous push with out_ready=1 at count=1 -> count stays 1, one word per cycle with no bubble.
REQ-039 Fill to 3 entries, pulse rst_n=0 for one edge -> count=0, out_valid=0, in_ready=1; the next legal request encodes normally.

Source files
------------

// File: rtl/insn_encoder_if.sv
// Request/response bundle between a producer of decoded ops and the RV32I encoder.
// The encoder uses the slave modport and the producer/consumer side uses the master modport.
interface insn_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [12:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_insn;
  logic        err_valid;
  logic [1:0]  err_code;
  logic [2:0]  count;

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_insn, err_valid, err_code, count
  );

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_insn, err_valid, err_code, count
  );
endinterface

// File: rtl/insn_encoder.sv
// Encodes a small RV32I subset (LW/SW/AND/OR/ADD/SUB/BEQ/BLT) into 32-bit words
// and queues them in a DEPTH-entry FIFO; illegal immediates raise a one-cycle error.
module insn_encoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  insn_encoder_if.slave bus
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 3;

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_SW  = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_BEQ = 3'd6,
    OP_BLT = 3'd7
  } op_e;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   head_q, head_d;
  logic          in_ready_q, out_valid_q;
  logic          err_valid_q, err_valid_d;
  logic [1:0]    err_code_q, err_code_d;

  logic [31:0]   word_c;
  logic [1:0]    code_c;
  logic          accept_c, push_c, pop_c;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Instruction word and legality of the presented request
  always_comb begin
    logic [12:0] imm;
    logic [2:0]  f3;
    logic [6:0]  f7;
    word_c = '0;
    code_c = 2'b00;
    imm    = bus.in_imm;
    f3     = 3'b000;
    f7     = 7'b0000000;
    case (op_e'(bus.in_op))
      OP_LW: begin
        word_c = {imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
        if (imm[12] != imm[11]) code_c = 2'b01;
      end
      OP_SW: begin
        word_c = {imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, imm[4:0], 7'b0100011};
        if (imm[12] != imm[11]) code_c = 2'b01;
      end
      OP_BEQ, OP_BLT: begin
        f3     = (op_e'(bus.in_op) == OP_BLT) ? 3'b100 : 3'b000;
        word_c = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, f3,
                  imm[4:1], imm[11], 7'b1100011};
        if (imm[0]) code_c = 2'b10;
      end
      default: begin
        case (op_e'(bus.in_op))
          OP_AND:  f3 = 3'b111;
          OP_OR:   f3 = 3'b110;
          OP_SUB:  f7 = 7'b0100000;
          default: f3 = 3'b000;
        endcase
        word_c = {f7, bus.in_rs2, bus.in_rs1, f3, bus.in_rd, 7'b0110011};
      end
    endcase
  end

  // FIFO bookkeeping; the head word is registered so out_insn never glitches
  always_comb begin
    accept_c    = bus.in_valid && in_ready_q;
    push_c      = accept_c && (code_c == 2'b00);
    pop_c       = out_valid_q && bus.out_ready;
    wr_ptr_d    = push_c ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop_c  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d     = count_q + CW'(push_c) - CW'(pop_c);
    head_d      = (push_c && (wr_ptr_q == rd_ptr_d)) ? word_c : mem_q[rd_ptr_d];
    err_valid_d = accept_c && (code_c != 2'b00);
    err_code_d  = accept_c ? code_c : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      head_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      if (push_c) mem_q[wr_ptr_q] <= word_c;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      head_q      <= head_d;
      in_ready_q  <= (count_d < CW'(DEPTH));
      out_valid_q <= (count_d != '0);
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_insn  = head_q;
  assign bus.err_valid = err_valid_q;
  assign bus.err_code  = err_code_q;
  assign bus.count     = count_q;

endmodule
